ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 171 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data bits + odd parity,
// stop, device ACK sampling, with a per-edge timeout guarding every wait on the device.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAITIDLE} state_t;

    state_t        state, state_n;
    logic          clk_meta, clk_sync, clk_prev;
    logic          dat_meta, dat_sync;
    logic [7:0]    shreg, shreg_n;
    logic          parity, parity_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [IW-1:0] inh_cnt, inh_cnt_n;
    logic [TW-1:0] tmo_cnt, tmo_cnt_n;
    logic          nack, nack_n;
    logic          busy_n, done_n, error_n, clk_oe_n, dat_oe_n;
    logic          fall, tmo_hit;

    // Synchronizers idle high so reset never looks like a falling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk_i;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat_i;
            dat_sync <= dat_meta;
        end
    end

    assign fall    = clk_prev & ~clk_sync;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            parity     <= 1'b0;
            bit_cnt    <= '0;
            inh_cnt    <= '0;
            tmo_cnt    <= '0;
            nack       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            parity     <= parity_n;
            bit_cnt    <= bit_cnt_n;
            inh_cnt    <= inh_cnt_n;
            tmo_cnt    <= tmo_cnt_n;
            nack       <= nack_n;
            busy       <= busy_n;
            done       <= done_n;
            error      <= error_n;
            ps2_clk_oe <= clk_oe_n;
            ps2_dat_oe <= dat_oe_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        parity_n  = parity;
        bit_cnt_n = bit_cnt;
        inh_cnt_n = inh_cnt;
        tmo_cnt_n = tmo_cnt;
        nack_n    = nack;
        busy_n    = busy;
        done_n    = 1'b0;
        error_n   = 1'b0;
        clk_oe_n  = ps2_clk_oe;
        dat_oe_n  = ps2_dat_oe;

        case (state)
            IDLE: begin
                if (start) begin
                    shreg_n   = data;
                    parity_n  = ~^data;
                    bit_cnt_n = '0;
                    inh_cnt_n = '0;
                    nack_n    = 1'b0;
                    busy_n    = 1'b1;
                    clk_oe_n  = 1'b1;
                    dat_oe_n  = 1'b0;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                    dat_oe_n = 1'b1;
                    state_n  = REQ;
                end else begin
                    inh_cnt_n = inh_cnt + 1'b1;
                end
            end
            REQ: begin
                // Start bit stays driven low; releasing the clock hands timing to the device.
                clk_oe_n  = 1'b0;
                tmo_cnt_n = '0;
                state_n   = BITS;
            end
            BITS, ACK, WAITIDLE: begin
                tmo_cnt_n = tmo_cnt + 1'b1;
                if (tmo_hit) begin
                    clk_oe_n = 1'b0;
                    dat_oe_n = 1'b0;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                    error_n  = 1'b1;
                    state_n  = IDLE;
                end else if (state == BITS) begin
                    if (fall) begin
                        tmo_cnt_n = '0;
                        bit_cnt_n = bit_cnt + 1'b1;
                        if (bit_cnt < 4'd8) begin
                            dat_oe_n = ~shreg[bit_cnt[2:0]];
                        end else if (bit_cnt == 4'd8) begin
                            dat_oe_n = ~parity;
                        end else begin
                            dat_oe_n = 1'b0;
                            state_n  = ACK;
                        end
                    end
                end else if (state == ACK) begin
                    if (fall) begin
                        tmo_cnt_n = '0;
                        nack_n    = dat_sync;
                        state_n   = WAITIDLE;
                    end
                end else begin
                    if (fall) begin
                        tmo_cnt_n = '0;
                    end
                    if (clk_sync && dat_sync) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        error_n = nack;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, PS/2 device model, scoreboard of expected
// frames checked by a monitor on every done pulse.
module tb_ps2_host_tx;
    localparam int INH  = 40;
    localparam int TMO  = 600;
    localparam int HALF = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       busy, done, error, ps2_clk_oe, ps2_dat_oe;
    logic       ps2_clk_i, ps2_dat_i;
    logic       dev_clk = 1'b0;
    logic       dev_dat = 1'b0;

    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk);
    assign ps2_dat_i = ~(ps2_dat_oe | dev_dat);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .start(start), .data(data),
        .busy(busy), .done(done), .error(error),
        .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [10:0] frame;
        bit          err;
        bit          chk_frame;
        bit          chk_tmo;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    exp_t        exp_q[$];
    chk_t        chk_q[$];
    int          tests  = 0;
    int          fails  = 0;
    int          n_done = 0;
    int          n_exp  = 0;
    logic [10:0] obs_frame = '0;

    // Reference frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = d[i];
            ones += int'(d[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name; c.act = act; c.exp = exp;
        chk_q.push_back(c);
    endtask

    task automatic expect_tx(input logic [10:0] f, input bit err, input bit cf, input bit ct);
        exp_t e;
        e.frame = f; e.err = err; e.chk_frame = cf; e.chk_tmo = ct;
        exp_q.push_back(e);
        n_exp++;
    endtask

    // Monitor: sole owner of the pass/fail counters.
    initial begin
        int   cyc;
        int   bits_t;
        logic prev_oe;
        exp_t e;
        chk_t c;
        cyc = 0; bits_t = 0; prev_oe = 1'b0;
        forever begin
            @(negedge clock);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                tests++;
                if (c.act !== c.exp) begin
                    fails++;
                    $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
                end
            end
            if (prev_oe && !ps2_clk_oe) bits_t = cyc;
            prev_oe = ps2_clk_oe;
            if (done === 1'b1) begin
                n_done++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse");
                end else begin
                    e = exp_q.pop_front();
                    if (error !== e.err || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
                        fails++;
                        $display("FAIL done_status: got err=%b busy=%b clk_oe=%b dat_oe=%b expected err=%b busy=0 oe=0",
                                 error, busy, ps2_clk_oe, ps2_dat_oe, e.err);
                    end
                    if (e.chk_frame) begin
                        tests += 2;
                        if (obs_frame !== e.frame) begin
                            fails++;
                            $display("FAIL frame: got %b expected %b (bit0 rightmost)", obs_frame, e.frame);
                        end
                        if (obs_frame[9] !== e.frame[9]) begin
                            fails++;
                            $display("FAIL parity: got %b expected %b", obs_frame[9], e.frame[9]);
                        end
                    end
                    if (e.chk_tmo) begin
                        tests++;
                        if (cyc - bits_t != TMO) begin
                            fails++;
                            $display("FAIL timeout_latency: got %0d expected %0d", cyc - bits_t, TMO);
                        end
                    end
                end
            end
            cyc++;
        end
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge clock);
        start = 1'b1;
        data  = d;
        @(negedge clock);
        start = 1'b0;
        data  = 8'($urandom);
        post("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Device: waits for request-to-send, clocks nfalls edges, records line bits, ACKs if asked.
    task automatic device(input int nfalls, input bit ack);
        int n;
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_i == 1'b0) && n < 4 * INH) begin
            @(negedge clock);
            n++;
        end
        if (n >= 4 * INH) begin
            post("request_to_send_seen", 32'd0, 32'd1);
            return;
        end
        repeat (10) @(negedge clock);
        obs_frame[0] = ps2_dat_i;
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clock);
            if (k <= 10) obs_frame[k] = ps2_dat_i;
            dev_clk = 1'b0;
            if (k == 10 && ack) begin
                repeat (HALF / 2) @(negedge clock);
                dev_dat = 1'b1;
                repeat (HALF - HALF / 2) @(negedge clock);
            end else if (k < 11) begin
                repeat (HALF) @(negedge clock);
            end
            if (k == 11) dev_dat = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(negedge clock);
            n++;
        end
        if (n >= bound) post("done_within_bound", 32'd0, 32'd1);
    endtask

    initial begin
        int          n_inh, n_req, n_before;
        logic [7:0]  d;
        bit          ack;
        logic [7:0]  sweep [3];
        sweep[0] = 8'h00; sweep[1] = 8'h01; sweep[2] = 8'hFF;

        repeat (3) @(negedge clock);
        post("reset_outputs", 32'({busy, done, error, ps2_clk_oe, ps2_dat_oe}), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 0xED with ACK, including inhibit and request-to-send timing.
        expect_tx(model_frame(8'hED), 1'b0, 1'b1, 1'b0);
        start_tx(8'hED);
        n_inh = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n_inh < 4 * INH) begin
            n_inh++;
            @(negedge clock);
        end
        n_req = 0;
        while (ps2_clk_oe && ps2_dat_oe && n_req < 10) begin
            n_req++;
            @(negedge clock);
        end
        post("inhibit_cycles", 32'(n_inh), 32'(INH));
        post("req_cycles", 32'(n_req), 32'd1);
        post("expected_frame_ed", 32'(model_frame(8'hED)), 32'b11111011010);
        device(11, 1'b1);
        wait_done(200);

        for (int i = 0; i < 3; i++) begin
            expect_tx(model_frame(sweep[i]), 1'b0, 1'b1, 1'b0);
            start_tx(sweep[i]);
            device(11, 1'b1);
            wait_done(200);
        end

        // NACK: device leaves data high at the ACK edge.
        expect_tx(model_frame(8'h5A), 1'b1, 1'b1, 1'b0);
        start_tx(8'h5A);
        device(11, 1'b0);
        wait_done(200);

        // Device never clocks.
        repeat (5) @(negedge clock);
        expect_tx('0, 1'b1, 1'b0, 1'b1);
        start_tx(8'h96);
        wait_done(INH + TMO + 100);

        // Second start mid-frame is ignored.
        repeat (5) @(negedge clock);
        expect_tx(model_frame(8'hC3), 1'b0, 1'b1, 1'b0);
        start_tx(8'hC3);
        fork
            device(11, 1'b1);
            begin
                repeat (INH + 200) @(negedge clock);
                data  = 8'h55;
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
                data  = 8'($urandom);
            end
        join
        wait_done(200);

        // Reset after falling edge 5: no done, next frame intact.
        repeat (5) @(negedge clock);
        n_before = n_done;
        start_tx(8'h3C);
        device(5, 1'b1);
        reset = 1'b1;
        #1;
        post("oe_on_reset", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (TMO + 50) @(negedge clock);
        post("no_done_after_reset", 32'(n_done), 32'(n_before));
        expect_tx(model_frame(8'hA5), 1'b0, 1'b1, 1'b0);
        start_tx(8'hA5);
        device(11, 1'b1);
        wait_done(200);

        // Random back-to-back transfers, each start issued the cycle after done.
        for (int i = 0; i < 8; i++) begin
            d   = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            expect_tx(model_frame(d), !ack, 1'b1, 1'b0);
            start_tx(d);
            device(11, ack);
            wait_done(200);
        end

        repeat (20) @(negedge clock);
        post("done_count", 32'(n_done), 32'(n_exp));
        post("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
